mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit sitting directly upstream of the stage-4 data memory. It accepts one memory request per cycle from the execute stage and drives the memory's read, write, word-address and byte-lane signals. When read data returns one cycle later, it selects the addressed bytes, sign- or zero-extends them, and registers the result toward writeback. Word-crossing (misaligned) accesses are either split into two aligned accesses or reported as faults, depending on build configuration.

## Interface
Parameters:
- `DATA_W`, 32: word width; matches the `word` type.

Ports:
- `clock` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present from execute.
- `req_ready` out 1: request accepted at an edge where `req_valid && req_ready`.
- `req_load` in 1: 1 = load, 0 = store.
- `req_funct3` in 3: RV32I size/sign field.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_rd` in 5: load destination register.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out 32: word-aligned address (`addr & ~3`).
- `mem_byte_en` out 4: bit i enables byte lane i (bits [8i+7:8i]).
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_read`.
- `wb_valid` out 1: registered load result valid (one-cycle pulse per load).
- `wb_data` out 32: extended load value.
- `wb_rd` out 5: destination register.
- `fault_valid` out 1: registered misalignment or illegal-`funct3` pulse.

## Operation
- Little-endian: address offset k = `addr[1:0]` maps to lane k.
- Accepted `funct3` values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value: no memory access, `fault_valid` pulses.
- Byte-lane mask: size mask (0001 / 0011 / 1111) shifted left by k. Bits carried past lane 3 are the spill part.
- Crossing: an access crosses a word boundary when k + size > 4. A non-crossing unaligned access (e.g. LH at offset 1 → lanes 0110) is a single access.
- Aligned (non-crossing) access:
  - `mem_*` are driven combinationally from the request in the accept cycle.
  - `mem_wdata = req_wdata << 8k`.
  - Loads: in the following cycle, `mem_rdata >> 8k` is masked to size and extended (signed for LB/LH, zero for LBU/LHU), then registered.
- Crossing access: FSM with states IDLE and SECOND.
  - IDLE → SECOND on accepting a crossing request. The first access goes to word A with the low lanes.
  - SECOND: `req_ready=0`. Drives word A+4 with the spill lanes; `mem_wdata` carries the spill bytes in the low lanes.
  - Loads in SECOND: low bytes from the A read are captured. Next cycle they are combined with the A+4 read, extended, and registered.
  - SECOND → IDLE unconditionally after one cycle.
- Request fields are latched at acceptance; upstream need not hold them.
- `mem_read` and `mem_write` are never both high. Unused lanes of `mem_wdata` are 0.
- When no access is issued: `mem_byte_en=0`, `mem_addr=0`.

## Timing
- Reset values: `wb_valid=0`, `wb_data=0`, `wb_rd=0`, `fault_valid=0`, state IDLE, all `mem_*` outputs 0, `req_ready=0` while `reset` is high.
- `req_ready` = (state == IDLE) && !`reset`.
- Aligned load accepted at edge E0: `wb_valid` high in the cycle after edge E0+1 (two-edge latency). Throughput is one load per cycle.
- Store: memory is written at the accept edge; no `wb_valid`.
- Crossing load accepted at E0: second access at E0+1, `wb_valid` after E0+2. Exactly one bubble on `req_ready`.
- Crossing store: two write edges, one bubble.
- Fault: `fault_valid` high the cycle after acceptance; no memory strobe, no `wb_valid`.
- Reset asserted in SECOND: the second access is abandoned and no `wb_valid` or fault is produced. After reset is released the unit is in IDLE.

## Configuration
- `MISALIGNED_SPLIT_EN` defined: crossing accesses are split as described; the FSM is present.
- Undefined: crossing accesses are treated as faults (no memory access, `fault_valid` pulse), `req_ready` is always high outside reset, and the SECOND state is removed.

## Structure
- Shared package `mem_access_pkg`:
  - `funct3` encoding constants.
  - Size enum (byte/half/word).
  - FSM state enum.
  - Lane-mask function.
- One sub-module, `load_extractor`: combinational byte select, shift and sign/zero extension from a 64-bit two-word window, offset and `funct3`. It is shared by the aligned and split paths.

## Test plan
- Memory word 0x100 = 0x8899AABB. LB at 0x103 → `mem_byte_en`=1000, `wb_data`=0xFFFFFF88, `wb_valid` two edges after accept.
- LHU at 0x102 on the same word → lanes 1100, `wb_data`=0x00008899. Back-to-back with the previous LB, `req_ready` never drops.
- SW 0xAABBCCDD to 0x205 (split enabled):
  - First access: `mem_addr`=0x204, `mem_byte_en`=1110, `mem_wdata`=0xBBCCDD00.
  - Second access: 0x208, 0001, 0x000000AA.
  - `req_ready` low for one cycle.
- LW at 0x102 with word 0x100=0x8899AABB and word 0x104=0x11223344 → `wb_data`=0x33448899, `wb_valid` three edges after accept. Without the macro: `fault_valid` pulse, no strobe.
- `funct3`=011 load → `fault_valid`=1, `mem_read`=0. Reset asserted in SECOND → no `wb_valid`; all outputs return to reset values.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, access sizes,
// FSM states and byte-lane mask generation.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // Eight lanes wide so that bits [7:4] hold the lanes spilling into the next word.
  function automatic logic [7:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      SZ_BYTE: base = 8'b0000_0001;
      SZ_HALF: base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] size_data_mask(input size_e sz);
    logic [31:0] m;
    case (sz)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extractor.sv
// load_extractor: picks the addressed bytes out of a two-word little-endian window
// and sign- or zero-extends them according to funct3.
module load_extractor
  import mem_access_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [63:0] shifted;
  logic [31:0] unused_hi;

  always_comb begin
    shifted   = window >> {offset, 3'b000};
    unused_hi = shifted[63:32];
    case (funct3)
      F3_B:    value = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    value = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   value = {24'b0, shifted[7:0]};
      F3_HU:   value = {16'b0, shifted[15:0]};
      default: value = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit driving the data memory and returning extended loads.
// Build option MISALIGNED_SPLIT_EN: split word-crossing accesses in two; otherwise they fault.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_byte_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              fault_valid,
  output logic              dbg_state
);

  // Handshake: a request transfers at a posedge where req_valid && req_ready;
  // its fields are captured then and need not be held afterwards.

  logic [1:0]          req_k;
  size_e               req_size;
  logic                req_legal;
  logic [7:0]          req_lanes;
  logic                req_cross;
  logic [2*DATA_W-1:0] wdata_wide;
  logic                accept;

  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          ld_k_q, ld_k_d;
  logic [2:0]          ld_f3_q, ld_f3_d;
  logic [4:0]          ld_rd_q, ld_rd_d;
  logic                fault_q, fault_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic                fin_now;
  logic [63:0]         ext_window;
  logic [31:0]         ext_value;

`ifdef MISALIGNED_SPLIT_EN
  state_e              state_q, state_d;
  logic                fin_pend_q, fin_pend_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [31:0]         sp_addr_q, sp_addr_d;
  logic [3:0]          sp_be_q, sp_be_d;
  logic [DATA_W-1:0]   sp_wdata_q, sp_wdata_d;
  logic                sp_load_q, sp_load_d;

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign dbg_state  = (state_q == ST_SECOND);
  assign fin_now    = fin_pend_q;
  assign ext_window = fin_pend_q ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
`else
  logic [DATA_W-1:0]   unused_spill;

  assign req_ready    = !reset;
  assign dbg_state    = 1'b0;
  assign fin_now      = 1'b0;
  assign ext_window   = {{DATA_W{1'b0}}, mem_rdata};
  assign unused_spill = wdata_wide[2*DATA_W-1:DATA_W];
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    req_k = req_addr[1:0];
    case (req_funct3[1:0])
      2'b00:   req_size = SZ_BYTE;
      2'b01:   req_size = SZ_HALF;
      default: req_size = SZ_WORD;
    endcase
    if (req_load) req_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else          req_legal = req_funct3 inside {F3_B, F3_H, F3_W};
    req_lanes  = lane_mask(req_size, req_k);
    req_cross  = |req_lanes[7:4];
    wdata_wide = {{DATA_W{1'b0}}, req_wdata & size_data_mask(req_size)} << {req_k, 3'b000};
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_byte_en = '0;
    mem_wdata   = '0;
    fault_d     = 1'b0;
    rd_pend_d   = 1'b0;
    ld_k_d      = ld_k_q;
    ld_f3_d     = ld_f3_q;
    ld_rd_d     = ld_rd_q;
`ifdef MISALIGNED_SPLIT_EN
    state_d     = state_q;
    fin_pend_d  = 1'b0;
    lo_d        = lo_q;
    sp_addr_d   = sp_addr_q;
    sp_be_d     = sp_be_q;
    sp_wdata_d  = sp_wdata_q;
    sp_load_d   = sp_load_q;
    if (state_q == ST_SECOND) begin
      // Second half goes to the next word; the first word's read data is here now.
      mem_read    = sp_load_q;
      mem_write   = !sp_load_q;
      mem_addr    = sp_addr_q + 32'd4;
      mem_byte_en = sp_be_q;
      mem_wdata   = sp_load_q ? '0 : sp_wdata_q;
      lo_d        = mem_rdata;
      fin_pend_d  = sp_load_q;
      state_d     = ST_IDLE;
    end else
`endif
    if (accept) begin
`ifdef MISALIGNED_SPLIT_EN
      if (!req_legal) begin
`else
      if (!req_legal || req_cross) begin
`endif
        fault_d = 1'b1;
      end else begin
        mem_read    = req_load;
        mem_write   = !req_load;
        mem_addr    = {req_addr[31:2], 2'b00};
        mem_byte_en = req_lanes[3:0];
        mem_wdata   = req_load ? '0 : wdata_wide[DATA_W-1:0];
        if (req_load) begin
          ld_k_d  = req_k;
          ld_f3_d = req_funct3;
          ld_rd_d = req_rd;
        end
`ifdef MISALIGNED_SPLIT_EN
        if (req_cross) begin
          state_d    = ST_SECOND;
          sp_addr_d  = {req_addr[31:2], 2'b00};
          sp_be_d    = req_lanes[7:4];
          sp_wdata_d = wdata_wide[2*DATA_W-1:DATA_W];
          sp_load_d  = req_load;
        end else begin
          rd_pend_d = req_load;
        end
`else
        rd_pend_d = req_load;
`endif
      end
    end
  end

  load_extractor u_extract (
    .window (ext_window),
    .offset (ld_k_q),
    .funct3 (ld_f3_q),
    .value  (ext_value)
  );

  always_comb begin
    wb_valid_d = rd_pend_q || fin_now;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    if (wb_valid_d) begin
      wb_data_d = ext_value;
      wb_rd_d   = ld_rd_q;
    end
  end

`ifdef MISALIGNED_SPLIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fin_pend_q <= 1'b0;
      lo_q       <= '0;
      sp_addr_q  <= '0;
      sp_be_q    <= '0;
      sp_wdata_q <= '0;
      sp_load_q  <= 1'b0;
    end else begin
      fin_pend_q <= fin_pend_d;
      lo_q       <= lo_d;
      sp_addr_q  <= sp_addr_d;
      sp_be_q    <= sp_be_d;
      sp_wdata_q <= sp_wdata_d;
      sp_load_q  <= sp_load_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      ld_k_q     <= '0;
      ld_f3_q    <= '0;
      ld_rd_q    <= '0;
      fault_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      ld_k_q     <= ld_k_d;
      ld_f3_q    <= ld_f3_d;
      ld_rd_q    <= ld_rd_d;
      fault_q    <= fault_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign fault_valid = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed steps from the test plan followed by a
// randomized request stream checked against a byte-level reference memory.
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] mem_rdata = '0;
  logic        req_ready, mem_read, mem_write, wb_valid, fault_valid, dbg_state;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_byte_en;
  logic [4:0]  wb_rd;

  mem_access_unit #(.DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_load    (req_load),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_byte_en (mem_byte_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .fault_valid (fault_valid),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  int          faults_exp = 0;
  int          faults_seen = 0;
  logic [36:0] exp_q[$];
  int          wb_cyc_log[$];
  logic [31:0] wb_dat_log[$];
  logic [7:0]  mem_bytes [0:1023];
  logic [7:0]  ref_bytes [0:1023];

  int          acc_cyc, stall;
  logic        obs_read, obs_write;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model attached to the DUT: writes land at the edge, reads return next cycle.
  always @(posedge clock) begin
    logic [9:0] base;
    base = mem_addr[9:0];
    if (mem_write) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i]) mem_bytes[base + 10'(i)] = mem_wdata[8*i +: 8];
    end
    if (mem_read)
      mem_rdata <= {mem_bytes[base + 10'd3], mem_bytes[base + 10'd2],
                    mem_bytes[base + 10'd1], mem_bytes[base]};
  end

  always @(negedge clock) begin
    logic [36:0] e;
    if (!reset) begin
      chk("rd_wr_exclusive", mem_read & mem_write, 0);
      if (wb_valid) begin
        wb_cyc_log.push_back(cyc);
        wb_dat_log.push_back(wb_data);
        if (exp_q.size() == 0) chk("wb_unexpected", wb_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("wb_result", {wb_rd, wb_data}, e);
        end
      end
      if (fault_valid) faults_seen++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic ld, input logic [2:0] f3);
    if (ld) return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    return f3 inside {3'b000, 3'b001, 3'b010};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = size_of(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[10'(a + 32'(i))];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w);
    for (int i = 0; i < size_of(f3); i++) ref_bytes[10'(a + 32'(i))] = w[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] w, input logic [4:0] rd);
    @(negedge clock);
    stall = 0;
    while (!req_ready && stall < 20) begin
      @(negedge clock);
      stall++;
    end
    if (stall >= 20) chk("ready_timeout", req_ready, 1);
    req_valid  = 1'b1;
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = w;
    req_rd     = rd;
    #1;
    obs_read  = mem_read;
    obs_write = mem_write;
    obs_addr  = mem_addr;
    obs_be    = mem_byte_en;
    obs_wdata = mem_wdata;
    if (!is_legal(ld, f3) || (!SPLIT && int'(a[1:0]) + size_of(f3) > 4)) faults_exp++;
    else if (ld) exp_q.push_back({rd, ref_load(a, f3)});
    else ref_store(a, f3, w);
    @(posedge clock);
    #1;
    acc_cyc    = cyc;
    req_valid  = 1'b0;
    req_load   = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_be"}, mem_byte_en, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_fault"}, fault_valid, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int a1, a2, w;
    for (int i = 0; i < 1024; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      mem_bytes[i] = b;
      ref_bytes[i] = b;
    end
    {mem_bytes[10'h103], mem_bytes[10'h102], mem_bytes[10'h101], mem_bytes[10'h100]} = 32'h8899AABB;
    {ref_bytes[10'h103], ref_bytes[10'h102], ref_bytes[10'h101], ref_bytes[10'h100]} = 32'h8899AABB;
    {mem_bytes[10'h107], mem_bytes[10'h106], mem_bytes[10'h105], mem_bytes[10'h104]} = 32'h11223344;
    {ref_bytes[10'h107], ref_bytes[10'h106], ref_bytes[10'h105], ref_bytes[10'h104]} = 32'h11223344;

    #1 reset = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // LB then LHU back to back on word 0x100
    wb_cyc_log.delete();
    wb_dat_log.delete();
    send(1'b1, 3'b000, 32'h103, $urandom, 5'd7);
    a1 = acc_cyc;
    chk("lb_read", obs_read, 1);
    chk("lb_addr", obs_addr, 32'h100);
    chk("lb_be", obs_be, 4'b1000);
    send(1'b1, 3'b101, 32'h102, $urandom, 5'd9);
    a2 = acc_cyc;
    chk("lhu_no_stall", stall, 0);
    chk("lhu_be", obs_be, 4'b1100);
    repeat (3) @(negedge clock);
    chk("lb_lhu_wb_count", wb_dat_log.size(), 2);
    chk("lb_data", wb_dat_log[0], 32'hFFFFFF88);
    chk("lb_latency_edges", wb_cyc_log[0] - a1 + 1, 2);
    chk("lhu_data", wb_dat_log[1], 32'h00008899);
    chk("lhu_latency_edges", wb_cyc_log[1] - a2 + 1, 2);

    // SW crossing into word 0x208
    send(1'b0, 3'b010, 32'h205, 32'hAABBCCDD, 5'd0);
    @(negedge clock);
    if (SPLIT) begin
      chk("sw1_write", obs_write, 1);
      chk("sw1_addr", obs_addr, 32'h204);
      chk("sw1_be", obs_be, 4'b1110);
      chk("sw1_wdata", obs_wdata, 32'hBBCCDD00);
      chk("sw2_write", mem_write, 1);
      chk("sw2_addr", mem_addr, 32'h208);
      chk("sw2_be", mem_byte_en, 4'b0001);
      chk("sw2_wdata", mem_wdata, 32'h000000AA);
      chk("sw2_ready_low", req_ready, 0);
    end else begin
      chk("sw_cross_no_write", obs_write, 0);
      chk("sw_cross_fault", fault_valid, 1);
    end

    // LW crossing words 0x100/0x104
    wb_cyc_log.delete();
    wb_dat_log.delete();
    send(1'b1, 3'b010, 32'h102, $urandom, 5'd12);
    a1 = acc_cyc;
    chk("lw_after_bubble_no_stall", stall, 0);
    if (SPLIT) begin
      chk("lw1_read", obs_read, 1);
      chk("lw1_addr", obs_addr, 32'h100);
      chk("lw1_be", obs_be, 4'b1100);
      repeat (4) @(negedge clock);
      chk("lw_wb_count", wb_dat_log.size(), 1);
      chk("lw_data", wb_dat_log[0], 32'h33448899);
      chk("lw_latency_edges", wb_cyc_log[0] - a1 + 1, 3);
    end else begin
      chk("lw_cross_no_read", obs_read, 0);
      @(negedge clock);
      chk("lw_cross_fault", fault_valid, 1);
    end

    // illegal funct3 on a load
    send(1'b1, 3'b011, 32'h300, $urandom, 5'd3);
    chk("f3_011_no_read", obs_read, 0);
    chk("f3_011_no_write", obs_write, 0);
    @(negedge clock);
    chk("f3_011_fault", fault_valid, 1);
    repeat (2) @(negedge clock);

    // reset while the split FSM is in its second cycle
    if (SPLIT) begin
      @(negedge clock);
      req_valid  = 1'b1;
      req_load   = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h1F2;
      req_rd     = 5'd4;
      @(posedge clock);
      #1 req_valid = 1'b0;
      chk("rst_in_second_state", dbg_state, 1);
      #1 reset = 1'b1;
      #1 check_reset_outputs("rst_second");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      chk("rst_second_ready_after", req_ready, 1);
      chk("rst_second_idle_after", dbg_state, 0);
    end

    // randomized stream
    for (int t = 0; t < 300; t++) begin
      logic ld;
      logic [2:0] f3;
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (ld) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end else f3 = 3'($urandom_range(0, 2));
      end else f3 = 3'($urandom_range(0, 7));
      send(ld, f3, 32'($urandom_range(0, 1015)), $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
    end

    // drain and final checks
    repeat (3) @(negedge clock);
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("wb_drain", exp_q.size(), 0);
    chk("fault_count", faults_seen, faults_exp);
    for (int i = 0; i < 1024; i += 4)
      chk($sformatf("mem_word_%03h", i),
          {mem_bytes[i+3], mem_bytes[i+2], mem_bytes[i+1], mem_bytes[i]},
          {ref_bytes[i+3], ref_bytes[i+2], ref_bytes[i+1], ref_bytes[i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
